// File: rtl/axi4l_master.sv
// axi4l_master: single-outstanding AXI4-Lite master bridging a simple command/response port.
module axi4l_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                r_rsp_valid, r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                w_aw_done, w_w_done;
    // A channel counts as done if it already handshook or is handshaking now.
    assign w_aw_done = !r_awvalid || m_awready;
    assign w_w_done  = !r_wvalid || m_wready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_addr    <= cmd_addr;
                    r_wdata   <= cmd_wdata;
                    r_wstrb   <= cmd_wstrb;
                    r_awvalid <= cmd_we;
                    r_wvalid  <= cmd_we;
                    r_arvalid <= !cmd_we;
                    r_state   <= cmd_we ? WADDR : RADDR;
                end
                WADDR: begin
                    if (m_awready) r_awvalid <= 1'b0;
                    if (m_wready) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WRESP;
                    end
                end
                WRESP: if (m_bvalid) begin
                    r_bready    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= |m_bresp;
                    r_state     <= IDLE;
                end
                RADDR: if (m_arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= RDATA;
                end
                RDATA: if (m_rvalid) begin
                    r_rready    <= 1'b0;
                    r_rsp_rdata <= m_rdata;
                    r_rsp_err   <= |m_rresp;
                    r_rsp_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign m_awaddr  = r_addr;
    assign m_araddr  = r_addr;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;
endmodule

// File: tb/tb_axi4l_master.sv
// tb_axi4l_master: directed bench for axi4l_master against a delay-configurable SRAM slave.
module tb_axi4l_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_awaddr, m_wdata, m_araddr;
    logic [31:0] m_rdata = '0;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;

    axi4l_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    logic spur = 1'b0;
    logic [31:0] mem [256] = '{default: '0};
    logic [7:0]  wa = '0, ra = '0;
    logic [31:0] wd = '0;
    logic [3:0]  ws = '0;

    // Slave drives its handshake signals on the falling edge, after counting its wait cycles.
    always @(negedge clk) begin
        if (!m_awvalid) begin m_awready = 1'b0; aw_c = 0; end
        else if (!m_awready) begin if (aw_c >= aw_dly) m_awready = 1'b1; else aw_c++; end
        if (!m_wvalid) begin m_wready = 1'b0; w_c = 0; end
        else if (!m_wready) begin if (w_c >= w_dly) m_wready = 1'b1; else w_c++; end
        if (!m_arvalid) begin m_arready = 1'b0; ar_c = 0; end
        else if (!m_arready) begin if (ar_c >= ar_dly) m_arready = 1'b1; else ar_c++; end
        if (!m_bready) begin m_bvalid = spur; b_c = 0; end
        else if (!m_bvalid) begin if (b_c >= b_dly) m_bvalid = 1'b1; else b_c++; end
        if (!m_rready) begin m_rvalid = spur; r_c = 0; end
        else if (!m_rvalid) begin
            if (r_c >= r_dly) begin m_rvalid = 1'b1; m_rdata = mem[ra]; end else r_c++;
        end
    end

    always @(posedge clk) begin
        if (m_awvalid && m_awready) wa = m_awaddr[9:2];
        if (m_wvalid && m_wready) begin wd = m_wdata; ws = m_wstrb; end
        if (m_arvalid && m_arready) ra = m_araddr[9:2];
        if (m_bvalid && m_bready)
            for (int i = 0; i < 4; i++) if (ws[i]) mem[wa][8*i +: 8] = wd[8*i +: 8];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_rsp = 0, viol = 0, aw_hi = 0, w_hi = 0, b_hi = 0, got_lat = 0, acc_cyc = 0;
    logic [31:0] got_data = '0, p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;
    logic        got_err = 1'b0, got_rdy = 1'b0, p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;

    // Monitor: response capture, per-channel valid counts and AXI valid/payload stability.
    always @(posedge clk) begin
        if (rsp_valid) begin
            n_rsp++;
            got_data = rsp_rdata;
            got_err  = rsp_err;
            got_rdy  = cmd_ready;
            got_lat  = cyc - acc_cyc;
        end
        if (m_awvalid) aw_hi++;
        if (m_wvalid) w_hi++;
        if (m_bready) b_hi++;
        if (rst_n) begin
            if (p_aw && (!m_awvalid || m_awaddr != p_awaddr)) viol++;
            if (p_w && (!m_wvalid || m_wdata != p_wdata || m_wstrb != p_wstrb)) viol++;
            if (p_ar && (!m_arvalid || m_araddr != p_araddr)) viol++;
        end
        p_aw = rst_n && m_awvalid && !m_awready;
        p_w  = rst_n && m_wvalid && !m_wready;
        p_ar = rst_n && m_arvalid && !m_arready;
        p_awaddr = m_awaddr;
        p_wdata  = m_wdata;
        p_wstrb  = m_wstrb;
        p_araddr = m_araddr;
    end

    int n_chk = 0, n_pass = 0, n_cmds = 0, n0 = 0, aw0 = 0, w0 = 0, b0 = 0;
    logic [2:0] post_vld = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n0 = n_rsp;
        @(posedge clk);
        acc_cyc = cyc; aw0 = aw_hi; w0 = w_hi; b0 = b_hi;
        @(negedge clk);
        post_vld = {m_awvalid, m_wvalid, m_arvalid};
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd();
        int t = 0;
        while (n_rsp == n0 && t < 200) begin @(negedge clk); t++; end
        n_cmds++;
        chk("rsp_count", n_rsp - n0, 1);
    endtask

    task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        issue(we, a, d, s);
        finish_cmd();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] sb [8] = '{default: '0};
        int s0;
        repeat (3) @(negedge clk);
        chk("rst_in_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_err}, 0);
        chk("rst_payload", {m_awaddr, m_wdata, m_wstrb}, 0);
        chk("prot", {m_awprot, m_arprot}, 0);

        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_valids", post_vld, 3'b110);
        chk("wr_lat", got_lat, 3);
        chk("wr_err", got_err, 0);
        chk("wr_rdy", got_rdy, 1);
        chk("wr_mem", mem[4], 32'hDEADBEEF);
        xfer(1'b0, 32'h10, 32'h0, 4'h0);
        chk("rd_valids", post_vld, 3'b001);
        chk("rd_lat", got_lat, 3);
        chk("rd_data", got_data, 32'hDEADBEEF);

        aw_dly = 3;
        xfer(1'b1, 32'h14, 32'hA5A5A5A5, 4'hF);
        chk("aw_late_aw_hi", aw_hi - aw0, 4);
        chk("aw_late_w_hi", w_hi - w0, 1);
        chk("aw_late_bready", b_hi - b0, 1);
        chk("aw_late_lat", got_lat, 6);
        aw_dly = 0; w_dly = 2;
        xfer(1'b1, 32'h18, 32'h5A5A5A5A, 4'hF);
        chk("w_late_aw_hi", aw_hi - aw0, 1);
        chk("w_late_w_hi", w_hi - w0, 3);
        chk("w_late_lat", got_lat, 5);
        w_dly = 0;

        m_bresp = 2'b11;
        xfer(1'b1, 32'h40, 32'h12345678, 4'hF);
        chk("bresp_err", got_err, 1);
        m_bresp = 2'b00;
        r_dly = 4; m_rresp = 2'b10;
        xfer(1'b0, 32'h40, 32'h0, 4'h0);
        chk("rd_slow_data", got_data, 32'h12345678);
        chk("rd_slow_err", got_err, 1);
        chk("rd_slow_lat", got_lat, 7);
        repeat (4) @(negedge clk);
        chk("rd_slow_single", n_rsp - n0, 1);
        r_dly = 0; m_rresp = 2'b00;

        xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        chk("b2b_wr_rdy", got_rdy, 1);
        xfer(1'b0, 32'h20, 32'h0, 4'h0);
        chk("b2b_rd_data", got_data, 32'hCAFEF00D);
        chk("b2b_rd_rdy", got_rdy, 1);
        xfer(1'b1, 32'h20, 32'h11223344, 4'h5);
        xfer(1'b0, 32'h20, 32'h0, 4'h0);
        chk("strb_data", got_data, 32'hCA22F044);

        b_dly = 20;
        issue(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
        repeat (2) @(negedge clk);
        chk("pre_rst_bready", m_bready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}, 0);
        chk("mid_rst_rsp", {rsp_rdata, rsp_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_dly = 0;
        repeat (15) @(negedge clk);
        chk("rst_no_rsp", n_rsp - n0, 0);
        xfer(1'b0, 32'h20, 32'h0, 4'h0);
        chk("post_rst_data", got_data, 32'hCA22F044);
        chk("post_rst_lat", got_lat, 3);

        s0 = n_rsp;
        spur = 1'b1;
        repeat (5) @(negedge clk);
        chk("spur_no_rsp", n_rsp - s0, 0);
        chk("spur_idle", cmd_ready, 1);
        chk("spur_rdata", rsp_rdata, 32'hCA22F044);
        spur = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            logic we;
            int k;
            logic [31:0] d;
            logic [3:0] s;
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            we = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 7);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            xfer(we, 32'h80 + 32'(4 * k), d, s);
            if (we) begin
                for (int j = 0; j < 4; j++) if (s[j]) sb[k][8*j +: 8] = d[8*j +: 8];
            end else chk("rnd_rd_data", got_data, sb[k]);
        end

        repeat (5) @(negedge clk);
        chk("axi_stability", viol, 0);
        chk("rsp_total", n_rsp, n_cmds);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
